// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw pins in, debounced levels and press/release pulses out.
// BUTTON_DEBOUNCE_LATCH_EN adds the sticky press latch and its clear.
interface button_debouncer_if #(
   parameter int NUM_BUTTONS = 4
);
   logic [NUM_BUTTONS-1:0] button_raw;
   logic [NUM_BUTTONS-1:0] button_state;
   logic [NUM_BUTTONS-1:0] button_press;
   logic [NUM_BUTTONS-1:0] button_release;
`ifdef BUTTON_DEBOUNCE_LATCH_EN
   logic [NUM_BUTTONS-1:0] clear_latched;
   logic [NUM_BUTTONS-1:0] press_latched;
`endif

   modport master (
      input  button_raw,
      output button_state, button_press, button_release
`ifdef BUTTON_DEBOUNCE_LATCH_EN
      , input clear_latched, output press_latched
`endif
   );

   modport slave (
      output button_raw,
      input  button_state, button_press, button_release
`ifdef BUTTON_DEBOUNCE_LATCH_EN
      , output clear_latched, input press_latched
`endif
   );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: per-button 2-FF sync + stability-counter debounce with press/release pulses.
// BUTTON_DEBOUNCE_LATCH_EN adds a sticky press latch cleared per bit by clear_latched.
module button_debouncer #(
   parameter int NUM_BUTTONS     = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input logic                clk,
   input logic                reset,
   button_debouncer_if.master bus
);
   localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {ST_STABLE, ST_COUNTING} state_t;

   logic [NUM_BUTTONS-1:0]                r_s1;
   logic [NUM_BUTTONS-1:0]                r_s;
   logic [NUM_BUTTONS-1:0]                r_q;
   logic [NUM_BUTTONS-1:0]                r_press;
   logic [NUM_BUTTONS-1:0]                r_release;
   logic [NUM_BUTTONS-1:0][CNT_WIDTH-1:0] r_cnt;

   state_t                                w_fsm [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0]                w_q_nxt;
   logic [NUM_BUTTONS-1:0]                w_press_nxt;
   logic [NUM_BUTTONS-1:0]                w_release_nxt;
   logic [NUM_BUTTONS-1:0][CNT_WIDTH-1:0] w_cnt_nxt;

   // Synchronizer, debounced level, counters and event pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1      <= '0;
         r_s       <= '0;
         r_q       <= '0;
         r_press   <= '0;
         r_release <= '0;
         r_cnt     <= '0;
      end else begin
         r_s1      <= bus.button_raw;
         r_s       <= r_s1;
         r_q       <= w_q_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   // Per channel: count while the synced input disagrees, flip and pulse on the last count
   always_comb begin
      w_q_nxt       = r_q;
      w_press_nxt   = '0;
      w_release_nxt = '0;
      w_cnt_nxt     = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         w_fsm[i] = (r_s[i] != r_q[i]) ? ST_COUNTING : ST_STABLE;
         if (w_fsm[i] == ST_COUNTING) begin
            if (r_cnt[i] == CNT_LAST) begin
               w_q_nxt[i]       = r_s[i];
               w_press_nxt[i]   = r_s[i];
               w_release_nxt[i] = ~r_s[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign bus.button_state   = r_q;
   assign bus.button_press   = r_press;
   assign bus.button_release = r_release;

`ifdef BUTTON_DEBOUNCE_LATCH_EN
   logic [NUM_BUTTONS-1:0] r_latched;

   // Sticky press flag; a press pulse overrides a clear in the same cycle
   always_ff @(posedge clk) begin
      if (reset) r_latched <= '0;
      else       r_latched <= (r_latched & ~bus.clear_latched) | r_press;
   end

   assign bus.press_latched = r_latched;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: table-driven scoreboard bench for button_debouncer (D=4 and D=1 instances).
module tb_button_debouncer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   button_debouncer_if #(.NUM_BUTTONS(4)) bus0 ();
   button_debouncer_if #(.NUM_BUTTONS(4)) bus1 ();

   button_debouncer #(.NUM_BUTTONS(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .bus(bus0)
   );
   button_debouncer #(.NUM_BUTTONS(4), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   typedef struct {
      logic       rst;
      logic [3:0] raw;
      logic [3:0] st;
      logic [3:0] pr;
      logic [3:0] rl;
   } vec_t;

   typedef struct {
      int         idx;
      logic [3:0] st;
      logic [3:0] pr;
      logic [3:0] rl;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%b expected=%b", name, idx, act, exp);
      end
   endtask

   task automatic add_n(input int n, input logic rst, input logic [3:0] raw,
                        input logic [3:0] st, input logic [3:0] pr, input logic [3:0] rl);
      for (int k = 0; k < n; k++) vecs.push_back('{rst, raw, st, pr, rl});
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("state", e.idx, bus0.button_state, e.st);
         check("press", e.idx, bus0.button_press, e.pr);
         check("release", e.idx, bus0.button_release, e.rl);
      end
   end

   task automatic tick(input logic [3:0] raw0, input logic [3:0] raw1, input logic [3:0] clr);
      bus0.button_raw = raw0;
      bus1.button_raw = raw1;
`ifdef BUTTON_DEBOUNCE_LATCH_EN
      bus0.clear_latched = clr;
`endif
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus0.button_raw = '0;
      bus1.button_raw = '0;
`ifdef BUTTON_DEBOUNCE_LATCH_EN
      bus0.clear_latched = '0;
      bus1.clear_latched = '0;
`endif
      // reset and idle
      add_n(3, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_n(2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // press b0: state after edge 5, one-cycle press
      add_n(5, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add_n(1, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
      add_n(2, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      // 3-cycle glitch on b1: never accepted
      add_n(3, 0, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
      add_n(6, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      // release b0
      add_n(5, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      add_n(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add_n(2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // b2 raw high, reset at edge 3, then full 6 edges
      add_n(3, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      add_n(1, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      add_n(5, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      add_n(1, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
      add_n(2, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
      // simultaneous: b0,b3 press while b2 releases
      add_n(5, 0, 4'b1001, 4'b0100, 4'b0000, 4'b0000);
      add_n(1, 0, 4'b1001, 4'b1001, 4'b1001, 4'b0100);
      add_n(2, 0, 4'b1001, 4'b1001, 4'b0000, 4'b0000);
      // staggered release: b3 one edge before b0
      add_n(1, 0, 4'b0001, 4'b1001, 4'b0000, 4'b0000);
      add_n(4, 0, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
      add_n(1, 0, 4'b0000, 4'b0001, 4'b0000, 4'b1000);
      add_n(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add_n(2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst;
         bus0.button_raw = vecs[i].raw;
         sb.push_back('{i, vecs[i].st, vecs[i].pr, vecs[i].rl});
         @(posedge clk);
         #2;
      end
      reset = 1'b0;
      check("scoreboard_drained", 0, 4'(sb.size()), 4'd0);

      // DEBOUNCE_CYCLES=1: state flips 2 edges after edge 0
      tick(4'b0000, 4'b0010, 4'b0000);
      check("d1_state_e0", 0, bus1.button_state, 4'b0000);
      tick(4'b0000, 4'b0010, 4'b0000);
      check("d1_state_e1", 1, bus1.button_state, 4'b0000);
      tick(4'b0000, 4'b0010, 4'b0000);
      check("d1_state_e2", 2, bus1.button_state, 4'b0010);
      check("d1_press_e2", 2, bus1.button_press, 4'b0010);
      tick(4'b0000, 4'b0010, 4'b0000);
      check("d1_press_e3", 3, bus1.button_press, 4'b0000);
      check("d1_release_e3", 3, bus1.button_release, 4'b0000);

`ifdef BUTTON_DEBOUNCE_LATCH_EN
      for (int k = 0; k < 5; k++) tick(4'b1000, 4'b0010, 4'b0000);
      check("latch_before_press", 4, bus0.press_latched, 4'b0000);
      tick(4'b1000, 4'b0010, 4'b0000);
      check("latch_press_pulse", 5, bus0.button_press, 4'b1000);
      tick(4'b1000, 4'b0010, 4'b0000);
      check("latch_set", 6, bus0.press_latched, 4'b1000);
      for (int k = 0; k < 7; k++) tick(4'b0000, 4'b0010, 4'b0000);
      check("latch_released_state", 0, bus0.button_state, 4'b0000);
      check("latch_persists", 0, bus0.press_latched, 4'b1000);
      tick(4'b0000, 4'b0010, 4'b1000);
      check("latch_cleared", 0, bus0.press_latched, 4'b0000);
      for (int k = 0; k < 6; k++) tick(4'b1000, 4'b0010, 4'b0000);
      check("latch_press2_pulse", 5, bus0.button_press, 4'b1000);
      tick(4'b1000, 4'b0010, 4'b1000);
      check("latch_set_beats_clear", 6, bus0.press_latched, 4'b1000);
      tick(4'b1000, 4'b0010, 4'b0000);
      check("latch_holds", 7, bus0.press_latched, 4'b1000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
